// File: rtl/utopia2_atm_tx_if.sv
// Cell-input handshake and Utopia level-2 transmit bus of utopia2_atm_tx.
// master = the ATM-layer transmitter, slave = the cell source and the PHY side.
interface utopia2_atm_tx_if #(
    parameter int DATA_W  = 8,
    parameter int NUM_PHY = 4
);
    localparam int PHY_AW = (NUM_PHY > 1) ? $clog2(NUM_PHY) : 1;

    logic               in_valid;
    logic               in_ready;
    logic [423:0]       in_cell;
    logic [PHY_AW-1:0]  in_phy;
    logic [NUM_PHY-1:0] tx_clav;
    logic [PHY_AW-1:0]  tx_addr;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_soc;
    logic               tx_en_n;

    modport master (
        input  in_valid, in_cell, in_phy, tx_clav,
        output in_ready, tx_addr, tx_data, tx_soc, tx_en_n
    );

    modport slave (
        output in_valid, in_cell, in_phy, tx_clav,
        input  in_ready, tx_addr, tx_data, tx_soc, tx_en_n
    );
endinterface

// File: rtl/utopia2_atm_tx.sv
// Utopia level-2 ATM transmit master: cell FIFO feeding a per-PHY word serialiser.
// Define UTOPIA_TX_HEC_GEN_EN to regenerate the HEC byte from the four header bytes.
//
// state  | meaning
// IDLE   | waiting for a buffered cell
// SELECT | PHY address presented, first word waits for its clav
// XFER   | streaming words, stalling while clav is low
// GAP    | one idle cycle after a finished cell
module utopia2_atm_tx #(
    parameter int DATA_W  = 8,
    parameter int NUM_PHY = 4,
    parameter int DEPTH   = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    utopia2_atm_tx_if.master bus,
    output logic [15:0]      cells_sent,
    output logic             err_bad_phy
);
    localparam int PHY_AW = (NUM_PHY > 1) ? $clog2(NUM_PHY) : 1;
    localparam int AW     = $clog2(DEPTH);
    localparam int NBYTES = (DATA_W == 16) ? 54 : 53;
    localparam int NWORDS = NBYTES * 8 / DATA_W;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [5:0]  LAST_IDX = 6'(NWORDS);

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_XFER, S_GAP} state_t;

    logic [423:0]      cell_mem [DEPTH];
    logic [PHY_AW-1:0] phy_mem  [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic              accept, phy_ok, push, pop;

    state_t            state_q;
    logic [5:0]        idx_q;
    logic [PHY_AW-1:0] tx_addr_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_soc_q, tx_en_n_q, err_bad_phy_q;
    logic [15:0]       cells_sent_q;

    logic [423:0]        head_cell;
    logic [7:0]          hec_byte;
    logic [8*NBYTES-1:0] stream;
    logic [DATA_W-1:0]   words [64];
    logic                last_done;

    assign bus.in_ready = (count_q != FULL_CNT);
    assign accept       = bus.in_valid && bus.in_ready;
    assign phy_ok       = int'(bus.in_phy) < NUM_PHY;
    assign push         = accept && phy_ok;
    assign last_done    = (idx_q == LAST_IDX);
    assign pop          = ((state_q == S_SELECT) || (state_q == S_XFER)) && last_done;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (!push && pop)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            err_bad_phy_q <= 1'b0;
        end else begin
            count_q       <= count_d;
            err_bad_phy_q <= accept && !phy_ok;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Cell storage is plain RAM; occupancy alone decides what is valid.
    always_ff @(posedge clk_in) begin
        if (push) begin
            cell_mem[wr_ptr_q] <= bus.in_cell;
            phy_mem[wr_ptr_q]  <= bus.in_phy;
        end
    end

    assign head_cell = cell_mem[rd_ptr_q];

`ifdef UTOPIA_TX_HEC_GEN_EN
    function automatic logic [7:0] crc8(input logic [31:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 31; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0};
            if (fb)
                c = c ^ 8'h07;
        end
        return c;
    endfunction

    assign hec_byte = crc8(head_cell[423:392]) ^ 8'h55;
`else
    assign hec_byte = head_cell[391:384];
`endif

    // The 16-bit bus carries an extra UDF byte after the HEC to keep 27 whole words.
    if (DATA_W == 16) begin : g_w16
        assign stream = {head_cell[423:392], hec_byte, 8'h00, head_cell[383:0]};
    end else begin : g_w8
        assign stream = {head_cell[423:392], hec_byte, head_cell[383:0]};
    end

    for (genvar k = 0; k < 64; k++) begin : g_word
        if (k < NWORDS) begin : g_used
            assign words[k] = stream[8*NBYTES-1 - k*DATA_W -: DATA_W];
        end else begin : g_pad
            assign words[k] = '0;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            tx_addr_q    <= '0;
            tx_data_q    <= '0;
            tx_soc_q     <= 1'b0;
            tx_en_n_q    <= 1'b1;
            cells_sent_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_en_n_q <= 1'b1;
                    tx_soc_q  <= 1'b0;
                    if (count_q != '0) begin
                        tx_addr_q <= phy_mem[rd_ptr_q];
                        idx_q     <= '0;
                        state_q   <= S_SELECT;
                    end
                end
                S_SELECT, S_XFER: begin
                    if (last_done) begin
                        cells_sent_q <= cells_sent_q + 16'd1;
                        tx_en_n_q    <= 1'b1;
                        tx_soc_q     <= 1'b0;
                        state_q      <= S_GAP;
                    end else if (bus.tx_clav[tx_addr_q]) begin
                        tx_data_q <= words[idx_q];
                        tx_en_n_q <= 1'b0;
                        tx_soc_q  <= (idx_q == 6'd0);
                        idx_q     <= idx_q + 6'd1;
                        state_q   <= S_XFER;
                    end else begin
                        tx_en_n_q <= 1'b1;
                        tx_soc_q  <= 1'b0;
                    end
                end
                S_GAP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_addr  = tx_addr_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_soc   = tx_soc_q;
    assign bus.tx_en_n  = tx_en_n_q;
    assign cells_sent   = cells_sent_q;
    assign err_bad_phy  = err_bad_phy_q;
endmodule
